// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// The state enum, the source-ID width helper and the rotate-priority pick function.
package fifo_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  localparam int MAX_REQ = 16;

  function automatic int src_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Returns {found, index} of the first set bit at or after ptr, wrapping at n-1.
  function automatic logic [4:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [3:0] ptr,
                                         input int n);
    logic [4:0] res;
    int j;
    res = '0;
    for (int k = n - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (req[j]) res = {1'b1, 4'(j)};
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arb_pick.sv
// Combinational rotate-priority pick over a masked request vector.
// Produces a one-hot grant, its encoded index and an any-grant flag.
module rr_arb_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  input  logic [W-1:0] rr_ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] gnt_idx_o,
  output logic         any_o
);

  logic [MAX_REQ-1:0] req_ext;
  logic [4:0]         pick;

  always_comb begin
    req_ext         = '0;
    req_ext[N-1:0]  = req_i & mask_i;
  end

  assign pick      = rr_pick(req_ext, 4'(rr_ptr_i), N);
  assign any_o     = pick[4];
  assign gnt_idx_o = W'(pick[3:0]);
  assign gnt_o     = any_o ? (N'(1) << gnt_idx_o) : '0;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async-FIFO write port, with a one-entry output register.
// Define FIFO_ARB_PKT_LOCK_EN to lock the grant to one requester until req_last.
//
//   state | meaning
//   ARB   | free round-robin selection on every beat
//   HOLD  | grant locked to owner until its req_last word is accepted
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WORDSIZE = 8,
  parameter int NUM_REQ  = 4,
  parameter int SRC_W    = src_w(NUM_REQ)
) (
  input  logic                        wclk,
  input  logic                        wrst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*WORDSIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        wfull,
  output logic                        winc,
  output logic [WORDSIZE-1:0]         wdata,
  output logic [SRC_W-1:0]            wsrc
);

  arb_state_e           state_q, state_d;
  logic [SRC_W-1:0]     owner_q, owner_d;
  logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [WORDSIZE-1:0]  wdata_q, wdata_d;
  logic [SRC_W-1:0]     wsrc_q, wsrc_d;

  logic [NUM_REQ-1:0]   elig_mask;
  logic [NUM_REQ-1:0]   gnt;
  logic [SRC_W-1:0]     gnt_idx;
  logic [SRC_W-1:0]     ptr_after;
  logic                 any_req;
  logic                 drain;
  logic                 load;

  assign elig_mask = (state_q == HOLD) ? (NUM_REQ'(1) << owner_q) : '1;

  rr_arb_pick #(
    .N (NUM_REQ),
    .W (SRC_W)
  ) u_pick (
    .req_i     (req_valid),
    .mask_i    (elig_mask),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (any_req)
  );

  assign ptr_after = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);

  // Gated by reset so no requester sees ready while the block is held in reset.
  assign drain = out_valid_q && !wfull;
  assign load  = wrst_n && any_req && (!out_valid_q || drain);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q  <= ARB;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef FIFO_ARB_PKT_LOCK_EN
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      unique case (state_q)
        ARB: begin
          if (req_last[gnt_idx]) begin
            rr_ptr_d = ptr_after;
          end else begin
            state_d = HOLD;
            owner_d = gnt_idx;
          end
        end
        HOLD: begin
          if (req_last[gnt_idx]) begin
            state_d  = ARB;
            rr_ptr_d = ptr_after;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;

  always_comb begin
    state_d  = ARB;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (load) rr_ptr_d = ptr_after;
  end
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    wdata_d     = wdata_q;
    wsrc_d      = wsrc_q;
    if (load) begin
      out_valid_d = 1'b1;
      wdata_d     = req_data[int'(gnt_idx)*WORDSIZE +: WORDSIZE];
      wsrc_d      = gnt_idx;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      out_valid_q <= 1'b0;
      wdata_q     <= '0;
      wsrc_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      wdata_q     <= wdata_d;
      wsrc_q      <= wsrc_d;
    end
  end

  always_comb begin
    req_ready = load ? gnt : '0;
    winc      = drain;
    wdata     = wdata_q;
    wsrc      = wsrc_q;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic
// checked against a per-beat reference model and an accept/write scoreboard.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 8;
`ifdef FIFO_ARB_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic           wclk = 1'b0;
  logic           wrst_n;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [N*W-1:0] req_data;
  logic           wfull, winc;
  logic [W-1:0]   wdata;
  logic [1:0]     wsrc;

  fifo_wr_arbiter #(.WORDSIZE(W), .NUM_REQ(N), .SRC_W(2)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .wsrc      (wsrc)
  );

  always #5 wclk = ~wclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one held word, a rotating start position and an optional packet owner.
  bit         m_valid;
  logic [7:0] m_data;
  int         m_src, m_ptr, m_owner;
  int         e_j;
  bit         e_load, e_drain;
  logic [7:0] sb[$];
  logic [7:0] acc_word;
  bit         acc_seen;

  task automatic m_reset();
    m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0; m_owner = -1;
    sb.delete();
  endtask

  task automatic apply(input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input logic [N-1:0] l, input logic f);
    int j;
    req_valid = v; req_data = d; req_last = l; wfull = f;
    #1;
    e_j = -1;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (e_j < 0 && v[j] && (m_owner < 0 || m_owner == j)) e_j = j;
    end
    e_drain = m_valid && !f;
    e_load  = (e_j >= 0) && (!m_valid || e_drain);
    chk("req_ready", 32'(req_ready), e_load ? 32'(1 << e_j) : 32'd0);
    chk("winc", 32'(winc), 32'(e_drain));
    chk("wdata", 32'(wdata), 32'(m_data));
    chk("wsrc", 32'(wsrc), 32'(m_src));
    if (winc) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else chk("sb_data", 32'(wdata), 32'(sb.pop_front()));
    end
    acc_seen = 0;
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) begin
        acc_seen = 1;
        acc_word = req_data[i*W +: W];
      end
  endtask

  task automatic tick();
    @(posedge wclk);
    if (acc_seen) sb.push_back(acc_word);
    if (e_load) begin
      m_valid = 1;
      m_data  = req_data[e_j*W +: W];
      m_src   = e_j;
      if (LOCK) begin
        if (m_owner < 0) begin
          if (req_last[e_j]) m_ptr = (e_j + 1) % N;
          else m_owner = e_j;
        end else if (req_last[e_j]) begin
          m_owner = -1;
          m_ptr   = (e_j + 1) % N;
        end
      end else begin
        m_ptr = (e_j + 1) % N;
      end
    end else if (e_drain) begin
      m_valid = 0;
    end
    @(negedge wclk);
  endtask

  task automatic pulse_reset();
    #2 wrst_n = 1'b0;
    #1;
    chk("rst_async_winc", 32'(winc), 32'd0);
    chk("rst_async_ready", 32'(req_ready), 32'd0);
    m_reset();
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  logic [N*W-1:0] dat;
  logic [N-1:0]   lst;
  int             cnt1;

  initial begin
    wrst_n = 1'b0; req_valid = '1; req_data = '0; req_last = '0; wfull = 1'b0;
    m_reset();
    acc_seen = 0;
    #2;
    chk("rst_winc", 32'(winc), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_wsrc", 32'(wsrc), 32'd0);
    @(negedge wclk);
    wrst_n = 1'b1;

    // All four valid with A0..A3: one word per cycle in strict rotation.
    for (int c = 0; c < 9; c++) begin
      apply('1, 32'hA3A2A1A0, '1, 1'b0);
      if (c >= 1) begin
        chk("t1_winc", 32'(winc), 32'd1);
        chk("t1_order", 32'(wdata), 32'(8'hA0 + 8'((c - 1) % 4)));
      end
      tick();
    end

    // Only requester 2, then 0 and 3 together.
    for (int c = 0; c < 5; c++) begin
      dat = '0; dat[2*W +: W] = 8'(8'h20 + c);
      apply(4'b0100, dat, '1, 1'b0);
      chk("t2_only2", 32'(req_ready), 32'h4);
      tick();
    end
    apply(4'b1001, 32'h30000010, '1, 1'b0);
    chk("t2_next3", 32'(req_ready), 32'h8);
    tick();
    apply(4'b1001, 32'h31000011, '1, 1'b0);
    chk("t2_then0", 32'(req_ready), 32'h1);
    tick();

    // Stall with 8'h55 held in the output register.
    apply(4'b0001, 32'h00000055, '1, 1'b0);
    tick();
    for (int c = 0; c < 3; c++) begin
      apply('1, 32'h44332211, '1, 1'b1);
      chk("t3_hold_winc", 32'(winc), 32'd0);
      chk("t3_hold_ready", 32'(req_ready), 32'd0);
      chk("t3_hold_data", 32'(wdata), 32'h55);
      tick();
    end
    apply('0, '0, '1, 1'b0);
    chk("t3_release_winc", 32'(winc), 32'd1);
    chk("t3_release_data", 32'(wdata), 32'h55);
    tick();
    apply('0, '0, '1, 1'b0);
    chk("t3_single_pulse", 32'(winc), 32'd0);
    tick();
    // Empty register while full: one word may still be taken in.
    apply(4'b0010, 32'h0000_6600, '1, 1'b1);
    tick();
    apply(4'b0010, 32'h0000_6700, '1, 1'b1);
    tick();
    apply('0, '0, '1, 1'b0);
    tick();

    // Asynchronous reset mid-stream.
    for (int c = 0; c < 3; c++) begin
      apply('1, 32'hB3B2B1B0, '1, 1'b0);
      tick();
    end
    apply('1, 32'hB3B2B1B0, '1, 1'b0);
    pulse_reset();
    apply('1, 32'hC3C2C1C0, '1, 1'b0);
    chk("t4_first_grant", 32'(req_ready), 32'h1);
    tick();

    // Packet stimulus: requester 1 sends 3-word packets while 0 and 2 are busy.
    apply('0, '0, '0, 1'b0);
    pulse_reset();
    cnt1 = 0;
    for (int c = 0; c < 16; c++) begin
      lst = 4'b1101;
      lst[1] = ((cnt1 % 3) == 2);
      dat = {8'h00, 8'(8'h20 + c), 8'(8'h10 + c), 8'(8'h00 + c)};
      apply(4'b0111, dat, lst, 1'b0);
      if (req_ready[1]) cnt1++;
      tick();
    end

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      apply(N'($urandom), $urandom, N'($urandom | $urandom), ($urandom_range(0, 2) == 0));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
